// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the memory-access stage.
//   mem_state_t  - access FSM state encoding
//   DM_BE_ALL    - byte enables for a full 64-bit access
//   byte_onehot  - one-hot byte enable for a single lane
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2,
      DONE = 2'd3
   } mem_state_t;

   localparam logic [7:0] DM_BE_ALL = 8'hFF;

   function automatic logic [7:0] byte_onehot(input logic [2:0] lane);
      byte_onehot = 8'h01 << lane;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data lane select.
//   rdata     in  64  raw read data from data memory
//   lane      in  3   byte lane (address bits [2:0])
//   byte_mode in  1   1 = byte load, zero-extend the selected lane
//   data      out 64  aligned load value
module mem_load_align (
   input  logic [63:0] rdata,
   input  logic [2:0]  lane,
   input  logic        byte_mode,
   output logic [63:0] data
);

   always_comb begin
      data = rdata;
      if (byte_mode) begin
         data = {56'd0, rdata[{lane, 3'b000} +: 8]};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WR.
// Runs a req/ack handshake with a variable-latency data memory and stalls
// the pipeline while an access is outstanding.
//
// Optional feature macro: MEM_STAGE_BYTE_EN (adds MemSize_in, byte loads/stores).
//
// Ports:
//   clk, reset (async, active-low)
//   alu_in, data2_in, rd_in, MemWrite_in, MemToReg_in, RegWrite_in  EX/MEM inputs
//   MemSize_in (MEM_STAGE_BYTE_EN only)  1 = byte access
//   dm_req, dm_we, dm_addr, dm_wdata, dm_be  registered memory request
//   dm_ack, dm_rdata                         memory response
//   wb_data, wb_rd, wb_RegWrite              to MEM/WR
//   stall                                    pipeline hold
//   bus_err                                  sticky error flag
//
// state | meaning
// IDLE  | no access in flight; launch on pending access
// BUSY  | dm_req held, waiting for dm_ack or timeout
// ERR   | misaligned or timed-out access; set bus_err, zero load buffer
// DONE  | result valid, pipeline advances at end of this cycle
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] alu_in,
   input  logic [63:0] data2_in,
   input  logic [4:0]  rd_in,
   input  logic        MemWrite_in,
   input  logic        MemToReg_in,
   input  logic        RegWrite_in,
`ifdef MEM_STAGE_BYTE_EN
   input  logic        MemSize_in,
`endif
   output logic        dm_req,
   output logic        dm_we,
   output logic [63:0] dm_addr,
   output logic [63:0] dm_wdata,
   output logic [7:0]  dm_be,
   input  logic        dm_ack,
   input  logic [63:0] dm_rdata,
   output logic [63:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_RegWrite,
   output logic        stall,
   output logic        bus_err
);

   // Counter value on the last BUSY cycle before timeout fires.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   mem_state_t  state_q, state_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [63:0] lbuf_q, lbuf_d;
   logic        bus_err_q, bus_err_d;
   logic        dm_req_q, dm_req_d;
   logic        dm_we_q, dm_we_d;
   logic [63:0] dm_addr_q, dm_addr_d;
   logic [63:0] dm_wdata_q, dm_wdata_d;
   logic [7:0]  dm_be_q, dm_be_d;

   logic        pending;
   logic        is_load;
   logic        misaligned;
   logic [7:0]  req_be;
   logic [63:0] req_wdata;
   logic [63:0] rdata_aligned;

   assign pending = MemWrite_in | MemToReg_in;
   // Both controls high is treated as a store.
   assign is_load = MemToReg_in & ~MemWrite_in;

`ifdef MEM_STAGE_BYTE_EN
   assign misaligned = ~MemSize_in & (alu_in[2:0] != 3'd0);
   assign req_be     = MemSize_in ? byte_onehot(alu_in[2:0]) : DM_BE_ALL;
   assign req_wdata  = MemSize_in ? {8{data2_in[7:0]}} : data2_in;

   mem_load_align u_load_align (
      .rdata     (dm_rdata),
      .lane      (alu_in[2:0]),
      .byte_mode (MemSize_in),
      .data      (rdata_aligned)
   );
`else
   assign misaligned    = (alu_in[2:0] != 3'd0);
   assign req_be        = DM_BE_ALL;
   assign req_wdata     = data2_in;
   assign rdata_aligned = dm_rdata;
`endif

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      lbuf_d     = lbuf_q;
      bus_err_d  = bus_err_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      dm_be_d    = dm_be_q;
      unique case (state_q)
         IDLE: begin
            if (pending) begin
               if (misaligned) begin
                  state_d = ERR;
               end else begin
                  state_d    = BUSY;
                  tmo_d      = 8'd0;
                  dm_req_d   = 1'b1;
                  dm_we_d    = MemWrite_in;
                  dm_addr_d  = alu_in;
                  dm_wdata_d = req_wdata;
                  dm_be_d    = req_be;
               end
            end
         end
         BUSY: begin
            // ack takes priority over a timeout in the same cycle
            if (dm_ack) begin
               lbuf_d   = rdata_aligned;
               dm_req_d = 1'b0;
               state_d  = DONE;
            end else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_q == TMO_LAST) begin
                  dm_req_d = 1'b0;
                  state_d  = ERR;
               end
            end
         end
         ERR: begin
            bus_err_d = 1'b1;
            lbuf_d    = 64'd0;
            state_d   = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tmo_q      <= 8'd0;
         lbuf_q     <= 64'd0;
         bus_err_q  <= 1'b0;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= 64'd0;
         dm_wdata_q <= 64'd0;
         dm_be_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         lbuf_q     <= lbuf_d;
         bus_err_q  <= bus_err_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         dm_be_q    <= dm_be_d;
      end
   end

   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign dm_be       = dm_be_q;
   assign bus_err     = bus_err_q;
   assign stall       = pending & (state_q != DONE);
   assign wb_data     = (is_load && (state_q == DONE)) ? lbuf_q : alu_in;
   assign wb_rd       = rd_in;
   assign wb_RegWrite = RegWrite_in;

endmodule
